shift_out: RTL
==============

# shift_out

Parallel-in, serial-out transmitter for the standard library. It is the drain-side counterpart to the library's capture and storage elements. It accepts a WIDTH-bit word through a load/ready handshake and presents it one bit per clock on `_Q`, with `_valid` framing. It can stall mid-word via `_E` and can accept the next word on the final bit cycle, so it streams with no gap.

## Interface
- WIDTH, 8, word width in bits; must be ≥ 2.
- `_clock`  input  1  sole clock; all state changes on the rising edge.
- `_reset`  input  1  synchronous, active-high reset.
- `_D`  input  WIDTH  parallel word, sampled only on an accepted load.
- `_load`  input  1  load request.
- `_E`  input  1  shift enable; low freezes an in-progress word.
- `_ready`  output  1  block can accept `_load` this cycle.
- `_Q`  output  1  current serial bit.
- `_QNOT`  output  1  always `~_Q`.
- `_valid`  output  1  `_Q` carries a word bit.
- `_done`  output  1  last bit of a word is being consumed this cycle.
- `_return`  output  1  equals `_Q`.

## Operation
- State machine has two states: IDLE and SHIFT. It also holds a WIDTH-bit shift register `sr` and a bit counter `cnt` of width $clog2(WIDTH).
- `_ready` = IDLE | (SHIFT & `cnt`==WIDTH-1 & `_E`).
- Accept = `_load` & `_ready`. On accept, the block loads `sr` from `_D`, clears `cnt` and enters SHIFT. If `_ready` is low, `_load` is ignored and `_D` is not sampled.
- In SHIFT:
  - `_valid`=1.
  - `_Q` is `sr[0]` (LSB-first default).
  - With `_E`=1, `sr` shifts by one and `cnt` increments.
  - With `_E`=0, `sr`, `cnt` and `_Q` all hold.
- Last bit: when `cnt`==WIDTH-1 and `_E`=1:
  - `_done`=1 (combinational).
  - Next state is SHIFT with the new word if accept occurs, else IDLE.
- In IDLE: `_valid`=0, `_Q`=0, `_done`=0.
- `_E` has no effect in IDLE.
- `_load` while in SHIFT, outside the last-bit cycle, is dropped silently.

## Timing
- Reset, synchronous: state goes to IDLE and `sr`, `cnt` clear. Output values after the reset edge:
  - `_Q`=0, `_QNOT`=1, `_return`=0.
  - `_valid`=0, `_done`=0.
  - `_ready`=1.
- Reset mid-word aborts the word immediately, with no `_done`.
- Reset has priority over a simultaneous `_load`.
- Latency: accept at edge t puts the first bit on `_Q` in cycle t+1. With `_E` held high, the last bit appears in cycle t+WIDTH, which is also the cycle `_done` is asserted.
- Each cycle with `_E`=0 during SHIFT adds exactly one cycle of latency.
- Back-to-back: accept during the last-bit cycle puts bit 0 of the new word in the very next cycle. `_valid` stays high continuously.
- Last-bit cycle with `_E`=0: `_ready`=0 and `_done`=0; the block waits there.
- `_QNOT` and `_return` follow `_Q` combinationally.

## Configuration
- Macro: `SHIFT_OUT_MSB_FIRST_EN`.
- Defined: `_Q`=`sr[WIDTH-1]` and `sr` shifts left; the word goes out MSB first.
- Undefined: LSB first, as described above.
- Handshake, timing and `_done` behaviour are identical either way.

## Structure
- Shared package `shift_out_pkg` holds:
  - the state encoding (IDLE=0, SHIFT=1);
  - the function computing counter width from WIDTH.
- One sub-module, `bit_counter`, with clear, enable, count and terminal-count outputs, instantiated with terminal value WIDTH-1.
- Shift register and FSM stay in the top module.

## Test plan
- Reset: assert `_reset` for 2 cycles with `_load`=1 → `_ready`=1, `_valid`=0, `_Q`=0, `_QNOT`=1; no word is accepted.
- WIDTH=8, `_D`=8'h1E, `_E`=1, accept at t:
  - Without the macro, `_Q` over cycles t+1..t+8 = 0,1,1,1,1,0,0,0.
  - `_done` is high only in cycle t+8; IDLE follows at t+9.
  - With `SHIFT_OUT_MSB_FIRST_EN`, the sequence is 0,0,0,1,1,1,1,0.
- Stall: same word with `_E`=0 in cycles t+3 and t+4:
  - `_Q` holds bit 2 over t+3..t+5.
  - `_done` moves to t+10.
- Back-to-back: send 8'hFF, then assert `_load` with `_D`=8'h00 in the `_done` cycle → `_valid` continuous, eight 1s immediately followed by eight 0s.
- Dropped load: `_load`=1 with `_D`=8'hAA at cycle t+4 of a word in flight → the current word is unchanged and IDLE follows at t+9.
- Mid-word reset at t+5 → from t+6, `_valid`=0 and `_ready`=1; no `_done` pulse.

Source files
------------

// File: rtl/shift_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_out_pkg
// Purpose  : Shared definitions for the shift_out serial transmitter:
//            FSM state encoding and the bit-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package shift_out_pkg;

  // Transmitter control states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter that must reach width-1. A floor of one bit keeps the
  // counter a legal vector even for degenerate widths.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_out_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bit_counter
// Purpose  : Up-counter with synchronous clear and a terminal-count flag.
// Ports    : i_clock  - clock (rising edge)
//            i_reset  - synchronous active-high reset, clears the count
//            i_clear  - synchronous clear, wins over i_en
//            i_en     - count enable
//            o_count  - current count
//            o_tc     - high while the count equals TERMINAL
// Revision : 1.0 - initial release
// ============================================================================
module bit_counter
  import shift_out_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 7
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] c_TC = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == c_TC);

endmodule
`default_nettype wire

// File: rtl/shift_out.sv
`default_nettype none
// ============================================================================
// Module   : shift_out
// Purpose  : Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word
//            through a load/ready handshake and emits it one bit per clock,
//            framed by o_valid. i_E low freezes a word in flight. The next
//            word may be accepted during the last-bit cycle for gapless
//            streaming.
// Config   : SHIFT_OUT_MSB_FIRST_EN - defined: MSB first; undefined: LSB first
// Ports    : i_clock  - clock (rising edge)
//            i_reset  - synchronous active-high reset
//            i_D      - parallel word, sampled only on an accepted load
//            i_load   - load request
//            i_E      - shift enable
//            o_ready  - a load is accepted this cycle if requested
//            o_Q      - current serial bit (0 when idle)
//            o_QNOT   - ~o_Q
//            o_valid  - o_Q carries a word bit
//            o_done   - last bit of the word is being consumed this cycle
//            o_return - copy of o_Q
// Revision : 1.0 - initial release
// ============================================================================
module shift_out
  import shift_out_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_D,
  input  logic             i_load,
  input  logic             i_E,
  output logic             o_ready,
  output logic             o_Q,
  output logic             o_QNOT,
  output logic             o_valid,
  output logic             o_done,
  output logic             o_return
);

  localparam int c_CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_sr;
  logic [WIDTH-1:0]   w_sr_shifted;
  logic               w_sr_out;
  logic [c_CNT_W-1:0] w_cnt;
  logic               w_tc;
  logic               w_shift;
  logic               w_last;
  logic               w_ready;
  logic               w_accept;
  logic               w_unused_cnt;

  // A bit is consumed only while shifting with the enable high; the word
  // ends when that happens on the terminal count.
  assign w_shift  = (r_state == SHIFT) & i_E;
  assign w_last   = w_shift & w_tc;
  assign w_ready  = (r_state == IDLE) | w_last;
  assign w_accept = i_load & w_ready;

  // Cleared on every word boundary so a following word (or the next load
  // from IDLE) always starts counting at zero.
  bit_counter #(
    .WIDTH    (c_CNT_W),
    .TERMINAL (WIDTH - 1)
  ) u_bit_counter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_accept | w_last),
    .i_en    (w_shift),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

  // Only the terminal flag steers the FSM; the raw count is informational.
  assign w_unused_cnt = ^w_cnt;

`ifdef SHIFT_OUT_MSB_FIRST_EN
  assign w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
  assign w_sr_out     = r_sr[WIDTH-1];
`else
  assign w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
  assign w_sr_out     = r_sr[0];
`endif

  // A new word overrides the shift of the outgoing last bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sr <= '0;
    end else if (w_accept) begin
      r_sr <= i_D;
    end else if (w_shift) begin
      r_sr <= w_sr_shifted;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_state_nxt = w_accept ? SHIFT : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_ready  = w_ready;
  assign o_valid  = (r_state == SHIFT);
  assign o_Q      = o_valid & w_sr_out;
  assign o_QNOT   = ~o_Q;
  assign o_return = o_Q;
  assign o_done   = w_last;

endmodule
`default_nettype wire
